// File: rtl/wb_obi_pkg.sv
// Shared types for the Wishbone-to-OBI bridge.
// State encoding and default timeout budget.
package wb_obi_pkg;

    localparam int unsigned DefTimeout = 256;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RESP,
        DONE,
        DRAIN
    } state_e;

endpackage

// File: rtl/wb_obi_timeout.sv
// Saturating response-timeout counter.
// Clears on clr_i, counts while en_i, flags expiry at the limit.
module wb_obi_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned CNT_WIDTH      = 9
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [CNT_WIDTH-1:0] Limit = CNT_WIDTH'(TIMEOUT_CYCLES);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise count up and hold at the limit
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != Limit)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A zero limit means the timeout is disabled
    assign expire_o = (TIMEOUT_CYCLES != 0) && en_i && (cnt_q == Limit);

endmodule

// File: rtl/wb_to_obi_bridge.sv
// Wishbone classic slave to OBI master bridge.
// One cycle at a time, with error, timeout and abandon handling.
module wb_to_obi_bridge
    import wb_obi_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = DefTimeout
) (
    input  logic                    clk_i,
    input  logic                    wb_rst_ni,
    input  logic                    wbs_cyc_i,
    input  logic                    wbs_stb_i,
    input  logic                    wbs_we_i,
    input  logic [DATA_WIDTH/8-1:0] wbs_sel_i,
    input  logic [ADDR_WIDTH-1:0]   wbs_adr_i,
    input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
    output logic                    wbs_ack_o,
    output logic                    wbs_err_o,
    output logic [DATA_WIDTH-1:0]   wbs_dat_o,
    output logic                    req_o,
    input  logic                    gnt_i,
    output logic [ADDR_WIDTH-1:0]   addr_o,
    output logic                    we_o,
    output logic [DATA_WIDTH/8-1:0] be_o,
    output logic [DATA_WIDTH-1:0]   wdata_o,
    input  logic                    rvalid_i,
    input  logic [DATA_WIDTH-1:0]   rdata_i,
    input  logic                    err_i,
    output logic                    busy_o
);

    localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
    localparam int unsigned CNT_WIDTH =
        (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  we;
        logic [BE_WIDTH-1:0]   be;
        logic [DATA_WIDTH-1:0] wdata;
    } obi_req_t;

    state_e                state_q, state_d;
    obi_req_t              obi_q, obi_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rerr_q, rerr_d;
    logic                  abandon_q, abandon_d;
    logic                  expire;
    logic                  tmo;
    logic                  wb_req;
    logic                  ack;
    logic                  err;
    logic                  req;

    assign wb_req = wbs_cyc_i & wbs_stb_i;

    wb_obi_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_WIDTH     (CNT_WIDTH)
    ) u_timeout (
        .clk_i   (clk_i),
        .rst_ni  (wb_rst_ni),
        .clr_i   (state_q == IDLE),
        .en_i    ((state_q == REQ) || (state_q == RESP)),
        .expire_o(expire)
    );

    // An abandoned cycle has already been terminated or dropped
    assign tmo = expire & ~abandon_q;

    // Next state, captured fields and Wishbone/OBI strobes
    always_comb begin
        state_d   = state_q;
        obi_d     = obi_q;
        rdata_d   = rdata_q;
        rerr_d    = rerr_q;
        abandon_d = abandon_q;
        ack       = 1'b0;
        err       = 1'b0;
        req       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (wb_req) begin
                    obi_d.addr  = wbs_adr_i;
                    obi_d.we    = wbs_we_i;
                    obi_d.be    = wbs_sel_i;
                    obi_d.wdata = wbs_dat_i;
                    state_d     = REQ;
                end
            end
            REQ: begin
                req = 1'b1;
                if (tmo) begin
                    err       = wb_req;
                    abandon_d = 1'b1;
                end
                if (!wbs_cyc_i) begin
                    abandon_d = 1'b1;
                end
                if (gnt_i) begin
                    state_d = abandon_d ? DRAIN : RESP;
                end
            end
            RESP: begin
                if (abandon_q) begin
                    if (rvalid_i) begin
                        abandon_d = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (rvalid_i) begin
                    if (!obi_q.we) begin
                        rdata_d = rdata_i;
                    end
                    rerr_d  = err_i;
                    state_d = DONE;
                end else if (tmo) begin
                    err       = wb_req;
                    abandon_d = 1'b1;
                    state_d   = DRAIN;
                end else if (!wbs_cyc_i) begin
                    abandon_d = 1'b1;
                    state_d   = DRAIN;
                end
            end
            DONE: begin
                ack     = wb_req & ~rerr_q;
                err     = wb_req & rerr_q;
                state_d = IDLE;
            end
            DRAIN: begin
                if (rvalid_i) begin
                    abandon_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= IDLE;
            obi_q     <= '0;
            rdata_q   <= '0;
            rerr_q    <= 1'b0;
            abandon_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            obi_q     <= obi_d;
            rdata_q   <= rdata_d;
            rerr_q    <= rerr_d;
            abandon_q <= abandon_d;
        end
    end

    assign wbs_ack_o = ack;
    assign wbs_err_o = err;
    assign wbs_dat_o = rdata_q;
    assign req_o     = req;
    assign addr_o    = obi_q.addr;
    assign we_o      = obi_q.we;
    assign be_o      = obi_q.be;
    assign wdata_o   = obi_q.wdata;
    assign busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_wb_to_obi_bridge.sv
// Bench for wb_to_obi_bridge with an 8-cycle timeout.
// Directed scenarios followed by randomized transactions.
module tb_wb_to_obi_bridge;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat;
    logic        ack_o, err_o;
    logic [31:0] dat_o;
    logic        req_o, gnt;
    logic [31:0] addr_o;
    logic        we_o;
    logic [3:0]  be_o;
    logic [31:0] wdata_o;
    logic        rvalid, rerr;
    logic [31:0] rdata;
    logic        busy_o;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_dat = '0;

    always #5 clk = ~clk;

    wb_to_obi_bridge #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk_i    (clk),
        .wb_rst_ni(rst_n),
        .wbs_cyc_i(cyc),
        .wbs_stb_i(stb),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(dat),
        .wbs_ack_o(ack_o),
        .wbs_err_o(err_o),
        .wbs_dat_o(dat_o),
        .req_o    (req_o),
        .gnt_i    (gnt),
        .addr_o   (addr_o),
        .we_o     (we_o),
        .be_o     (be_o),
        .wdata_o  (wdata_o),
        .rvalid_i (rvalid),
        .rdata_i  (rdata),
        .err_i    (rerr),
        .busy_o   (busy_o)
    );

    task automatic chk(input string tag, input logic [95:0] obs,
                       input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transaction, entered just after a rising edge.
    // g: cycles from req to gnt; r: cycles from gnt to rvalid.
    task automatic do_txn(input logic t_we, input logic [31:0] t_adr,
                          input logic [3:0] t_sel, input logic [31:0] t_dat,
                          input int g, input int r,
                          input logic [31:0] t_rd, input logic t_re);
        int   gnt_c, rv_c, term, bend;
        logic terr;
        gnt_c = 1 + g;
        rv_c  = gnt_c + r;
        if (rv_c <= 1 + T) begin
            term = rv_c + 1;
            terr = t_re;
            bend = rv_c + 2;
            if (!t_we) exp_dat = t_rd;
        end else begin
            term = 1 + T;
            terr = 1'b1;
            bend = rv_c + 1;
        end
        for (int n = 0; n <= bend; n++) begin
            cyc    = (n <= term);
            stb    = (n <= term);
            we     = t_we;
            adr    = t_adr;
            sel    = t_sel;
            dat    = t_dat;
            gnt    = (n == gnt_c);
            rvalid = (n == rv_c);
            rdata  = (n == rv_c) ? t_rd : $urandom;
            rerr   = (n == rv_c) ? t_re : 1'($urandom);
            @(negedge clk);
            chk("req", req_o, (n >= 1 && n <= gnt_c));
            if (n >= 1 && n <= gnt_c)
                chk("aphase", {addr_o, we_o, be_o, wdata_o},
                    {t_adr, t_we, t_sel, t_dat});
            chk("ack", ack_o, (n == term && !terr));
            chk("err", err_o, (n == term && terr));
            chk("busy", busy_o, (n >= 1 && n < bend));
            @(posedge clk);
            #1;
        end
        chk("rdata", dat_o, exp_dat);
    endtask

    initial begin
        logic [31:0] b_adr, b_rd, junk;
        rst_n  = 1'b0;
        cyc    = 1'b0;
        stb    = 1'b0;
        we     = 1'b0;
        sel    = '0;
        adr    = '0;
        dat    = '0;
        gnt    = 1'b0;
        rvalid = 1'b0;
        rdata  = '0;
        rerr   = 1'b0;
        #12;
        chk("rst_out", {ack_o, err_o, req_o, we_o, busy_o, be_o},
            '0);
        chk("rst_dat", {dat_o, addr_o, wdata_o}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_txn(1'b0, 32'h3000_0010, 4'hF, 32'h0, 0, 1,
               32'hDEAD_BEEF, 1'b0);
        do_txn(1'b1, 32'h3000_0020, 4'b0011, 32'h1234_5678, 5, 1,
               32'h0, 1'b0);
        do_txn(1'b0, 32'h3000_0030, 4'hF, 32'h0, 1, 2,
               32'hCAFE_0001, 1'b1);
        do_txn(1'b0, 32'h3000_0040, 4'hF, 32'h0, 0, 19,
               32'hBAD0_BAD0, 1'b0);
        do_txn(1'b0, 32'h3000_0050, 4'hF, 32'h0, 0, 1,
               32'h5555_AAAA, 1'b0);

        // master drops cyc in RESP; new stb waits out the drain
        b_adr = 32'h3000_0060;
        b_rd  = 32'h0BAD_F00D;
        junk  = 32'h1111_2222;
        for (int n = 0; n <= 10; n++) begin
            cyc    = (n <= 1) || (n >= 3 && n <= 9);
            stb    = cyc;
            we     = 1'b0;
            sel    = 4'hF;
            adr    = (n < 3) ? 32'h3000_0070 : b_adr;
            gnt    = (n == 1) || (n == 7);
            rvalid = (n == 5) || (n == 8);
            rdata  = (n == 5) ? junk : b_rd;
            rerr   = 1'b0;
            @(negedge clk);
            chk("ab_ack", ack_o, (n == 9));
            chk("ab_err", err_o, 1'b0);
            chk("ab_req", req_o, (n == 1) || (n == 7));
            chk("ab_busy", busy_o,
                (n >= 1 && n <= 5) || (n >= 7 && n <= 9));
            if (n == 6) chk("ab_keep", dat_o, exp_dat);
            if (n == 7) chk("ab_addr", addr_o, b_adr);
            @(posedge clk);
            #1;
        end
        exp_dat = b_rd;
        chk("ab_rdata", dat_o, exp_dat);

        // asynchronous reset while waiting in RESP
        for (int n = 0; n <= 2; n++) begin
            cyc    = 1'b1;
            stb    = 1'b1;
            we     = 1'b0;
            adr    = 32'h3000_0080;
            gnt    = (n == 1);
            rvalid = 1'b0;
            @(negedge clk);
            if (n < 2) begin
                @(posedge clk);
                #1;
            end
        end
        chk("pre_rst_busy", busy_o, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out", {req_o, busy_o, ack_o, err_o}, '0);
        chk("arst_dat", dat_o, '0);
        exp_dat = '0;
        cyc = 1'b0;
        stb = 1'b0;
        gnt = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_txn(1'b0, 32'h3000_0090, 4'hF, 32'h0, 0, 1,
               32'h600D_600D, 1'b0);

        for (int i = 0; i < 12; i++) begin
            int g, r;
            g = $urandom_range(0, 3);
            r = (i % 4 == 3) ? $urandom_range(6, 12) : $urandom_range(1, 3);
            do_txn(1'($urandom), $urandom, 4'($urandom), $urandom, g, r,
                   $urandom, ($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_to_obi_bridge.md
Name: wb_to_obi_bridge

Overview:
- Parametrised, registered successor to the Caravel-side Wishbone-slave to OBI-master bridge.
- Converts one Wishbone classic cycle at a time into an OBI A-phase/R-phase pair.
- Adds:
  - configurable address and data widths;
  - an OBI response (rvalid) wait for writes as well as reads;
  - OBI error propagation to the Wishbone bus;
  - a response timeout;
  - safe abandonment of a cycle that the master drops or that times out.
- Sits between the management-SoC Wishbone port and the user-project OBI interconnect.

Parameters:
- ADDR_WIDTH, 32, width of wbs_adr_i and addr_o.
- DATA_WIDTH, 32, data width; must be a multiple of 8; BE_WIDTH = DATA_WIDTH/8.
- TIMEOUT_CYCLES, 256, cycles allowed in REQ+RESP before a Wishbone error; 0 disables the timeout.
- CNT_WIDTH, $clog2(TIMEOUT_CYCLES+1), width of the timeout counter (derived, not overridden).

Ports:
- clk_i  in  1  system clock
- wb_rst_ni  in  1  asynchronous active-low reset
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_stb_i  in  1  Wishbone strobe
- wbs_we_i  in  1  Wishbone write enable
- wbs_sel_i  in  BE_WIDTH  byte selects
- wbs_adr_i  in  ADDR_WIDTH  address
- wbs_dat_i  in  DATA_WIDTH  write data
- wbs_ack_o  out  1  normal termination
- wbs_err_o  out  1  error termination
- wbs_dat_o  out  DATA_WIDTH  read data (registered)
- req_o  out  1  OBI request
- gnt_i  in  1  OBI grant
- addr_o  out  ADDR_WIDTH  OBI address (registered)
- we_o  out  1  OBI write enable
- be_o  out  BE_WIDTH  OBI byte enables
- wdata_o  out  DATA_WIDTH  OBI write data
- rvalid_i  in  1  OBI response valid
- rdata_i  in  DATA_WIDTH  OBI read data
- err_i  in  1  OBI response error, qualified by rvalid_i
- busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset (wb_rst_ni low, asynchronous):
  - state = IDLE;
  - all outputs 0, including wbs_dat_o, addr_o, be_o, wdata_o;
  - timeout counter = 0; abandon flag = 0.
- States: IDLE, REQ, RESP, DONE, DRAIN.
- IDLE:
  - If wbs_cyc_i && wbs_stb_i: latch adr/we/sel/dat into the OBI output registers, then go to REQ.
  - Earliest req_o is one cycle after stb is sampled.
- REQ:
  - req_o = 1; addr_o/we_o/be_o/wdata_o stay constant until gnt (OBI rule: req_o never drops before gnt_i).
  - On gnt_i: go to RESP if the abandon flag is 0, else go to DRAIN.
- RESP:
  - Wait for rvalid_i, for reads and writes alike.
  - On rvalid_i: capture rdata_i into wbs_dat_o for reads (hold the previous value for writes), record err_i, go to DONE.
- DONE: one cycle.
  - If wbs_cyc_i && wbs_stb_i: pulse wbs_ack_o (err_i recorded 0) or wbs_err_o (err_i recorded 1).
  - Otherwise pulse nothing.
  - Then go to IDLE.
- Latency: stb at cycle 0, req_o at 1, gnt at 1, rvalid at 2 → ack at 3.
- ack and err are mutually exclusive, each exactly one cycle per transaction.
- Timeout:
  - The counter increments every cycle in REQ and RESP and clears in IDLE.
  - When it reaches TIMEOUT_CYCLES: pulse wbs_err_o for one cycle (only if cyc && stb) and set the abandon flag.
  - From RESP, go to DRAIN. In REQ, keep req_o asserted until gnt, then go to DRAIN.
- Master abort (wbs_cyc_i low in REQ or RESP):
  - Set the abandon flag; the OBI transaction still completes; no Wishbone termination is issued.
  - RESP with abandon set goes to DRAIN.
- DRAIN:
  - Wait for rvalid_i, discard the response (wbs_dat_o unchanged), clear the abandon flag, go to IDLE.
  - Wishbone requests are not accepted until IDLE.
- Simultaneous events:
  - rvalid_i in the same cycle the timeout expires: rvalid wins, normal DONE, no error.
  - rvalid_i while in REQ is a protocol violation and is ignored.
- Back-to-back: a new stb is sampled in the IDLE cycle after DONE; minimum 4 cycles per transaction.

Decomposition:
- Package wb_obi_pkg:
  - state enum (IDLE/REQ/RESP/DONE/DRAIN);
  - a default-timeout localparam;
  - an obi_req struct (addr, we, be, wdata) for the registered A-phase fields.
- One sub-module is natural: wb_obi_timeout (loadable counter with clear, enable and an expire pulse, parametrised on TIMEOUT_CYCLES).

Test Plan:
- Read: adr=0x3000_0010, gnt same cycle as req, rvalid 1 cycle later with rdata=0xDEADBEEF → ack at cycle 3, wbs_dat_o=0xDEADBEEF, one ack pulse.
- Write with sel=4'b0011, gnt delayed 5 cycles → addr_o/be_o/wdata_o stable through all 5 stall cycles; ack only after rvalid.
- Read completing with rvalid & err_i=1 → wbs_err_o one cycle, wbs_ack_o stays 0.
- TIMEOUT_CYCLES=8, gnt given, rvalid withheld → wbs_err_o 8 cycles after req. A late rvalid at cycle 20 is discarded and busy_o falls the next cycle; a following read succeeds.
- cyc dropped in RESP, rvalid 3 cycles later → no ack/err; state returns to IDLE, and a new stb meanwhile waits.
- Reset asserted asynchronously in RESP → req_o, busy_o, wbs_ack_o low immediately; after release, a read completes normally.
